// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg : shared FSM state encoding for the bit-serial subtractor
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package serial_pkg;

  // 2'd3 is unused and recovers to ST_IDLE in the FSM
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

endpackage

`default_nettype wire

// File: rtl/serial_sub_if.sv
// ---------------------------------------------------------------------------
// serial_sub_if : request/result bundle between a client and serial_sub
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

`default_nettype wire

// File: rtl/fullsub.sv
// ---------------------------------------------------------------------------
// fullsub : one-bit full subtractor, D = A - B - C with borrow-out
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fullsub (
  input  wire logic A,
  input  wire logic B,
  input  wire logic C,
  output logic      D,
  output logic      Bout
);

  assign D    = A ^ B ^ C;
  assign Bout = (~A & (B | C)) | (B & C);

endmodule

`default_nettype wire

// File: rtl/serial_sub.sv
// ---------------------------------------------------------------------------
// serial_sub : bit-serial WIDTH-bit subtractor (a - b - bin), LSB first
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_sub
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic   clk,
  input  wire logic   rst,
  serial_sub_if.slave bus
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] a_sh_q,    a_sh_d;
  logic [WIDTH-1:0] b_sh_q,    b_sh_d;
  logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
  logic [WIDTH-1:0] diff_q,    diff_d;
  logic [CW-1:0]    count_q,   count_d;
  logic             brw_q,     brw_d;
  logic             bout_q,    bout_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;

  logic             fs_d;
  logic             fs_bout;

  fullsub u_fullsub (
    .A    (a_sh_q[0]),
    .B    (b_sh_q[0]),
    .C    (brw_q),
    .D    (fs_d),
    .Bout (fs_bout)
  );

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    diff_sh_d = diff_sh_q;
    diff_d    = diff_q;
    count_d   = count_q;
    brw_d     = brw_q;
    bout_d    = bout_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_sh_d    = bus.a;
          b_sh_d    = bus.b;
          brw_d     = bus.bin;
          count_d   = '0;
          diff_sh_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        diff_sh_d = {fs_d, diff_sh_q[WIDTH-1:1]};
        brw_d     = fs_bout;
        count_d   = count_q + CW'(1);
        // Last bit: publish the completed result alongside the transition
        if (count_q == CNT_LAST) begin
          diff_d  = {fs_d, diff_sh_q[WIDTH-1:1]};
          bout_d  = fs_bout;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_sh_q <= '0;
      diff_q    <= '0;
      count_q   <= '0;
      brw_q     <= 1'b0;
      bout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      diff_sh_q <= diff_sh_d;
      diff_q    <= diff_d;
      count_q   <= count_d;
      brw_q     <= brw_d;
      bout_q    <= bout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_sub.sv
// ---------------------------------------------------------------------------
// tb_serial_sub : directed and randomised self-checking bench for serial_sub
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_sub;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  serial_sub_if #(.WIDTH(8)) bus ();

  serial_sub #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request, scramble operands after accept, wait for done (bounded).
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                        output int cyc, output logic busy1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_;
    bus.bin   = tbin;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~ta;
    bus.b     = ~tb_;
    bus.bin   = ~tbin;
    busy1     = bus.busy;
    cyc       = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.done) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    tests++; if (bus.diff !== 8'h00) begin fails++; $display("FAIL reset_diff got=%h exp=00", bus.diff); end
    tests++; if (bus.bout !== 1'b0) begin fails++; $display("FAIL reset_bout got=%b exp=0", bus.bout); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int   cyc;
    logic busy1;
    run_op(8'h05, 8'h03, 1'b0, cyc, busy1);
    tests++; if (busy1 !== 1'b1) begin fails++; $display("FAIL basic_busy got=%b exp=1", busy1); end
    tests++; if (cyc !== 8) begin fails++; $display("FAIL basic_latency got=%0d exp=8", cyc); end
    tests++; if ({bus.bout, bus.diff} !== 9'h002) begin
      fails++; $display("FAIL basic_result got=%b/%h exp=0/02", bus.bout, bus.diff);
    end
    @(negedge clk);
    tests++; if ({bus.busy, bus.done} !== 2'b00) begin
      fails++; $display("FAIL basic_idle busy/done got=%b exp=00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_hold();
    int   cyc;
    logic busy1;
    run_op(8'h03, 8'h05, 1'b0, cyc, busy1);
    tests++; if (cyc !== 8 || {bus.bout, bus.diff} !== 9'h1FE) begin
      fails++; $display("FAIL hold_result cyc=%0d got=%b/%h exp=8 1/fe", cyc, bus.bout, bus.diff);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++; if ({bus.done, bus.bout, bus.diff} !== 10'h1FE) begin
        fails++; $display("FAIL hold_cycle%0d got done=%b %b/%h exp done=0 1/fe", i, bus.done, bus.bout, bus.diff);
      end
    end
  endtask

  task automatic test_borrow_edges();
    int   cyc;
    logic busy1;
    run_op(8'h00, 8'h00, 1'b1, cyc, busy1);
    tests++; if (cyc !== 8 || {bus.bout, bus.diff} !== 9'h1FF) begin
      fails++; $display("FAIL zero_minus_bin cyc=%0d got=%b/%h exp=8 1/ff", cyc, bus.bout, bus.diff);
    end
    run_op(8'hFF, 8'hFF, 1'b1, cyc, busy1);
    tests++; if (cyc !== 8 || {bus.bout, bus.diff} !== 9'h1FF) begin
      fails++; $display("FAIL ff_minus_ff_bin cyc=%0d got=%b/%h exp=8 1/ff", cyc, bus.bout, bus.diff);
    end
  endtask

  task automatic test_ignore_start();
    int         pulses;
    logic [8:0] res;
    pulses = 0;
    res    = 9'h000;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h01; bus.bin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 3) begin
        bus.start = 1'b1; bus.a = 8'h00; bus.b = 8'h00;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done) begin
        pulses++;
        res = {bus.bout, bus.diff};
      end
    end
    bus.start = 1'b0;
    tests++; if (pulses !== 1) begin fails++; $display("FAIL ignore_pulses got=%0d exp=1", pulses); end
    tests++; if (res !== 9'h00F) begin fails++; $display("FAIL ignore_result got=%h exp=00f", res); end
  endtask

  task automatic test_rst_mid();
    int pulses;
    pulses = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h33; bus.b = 8'h11; bus.bin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++; if ({bus.busy, bus.done, bus.bout, bus.diff} !== 11'h000) begin
      fails++; $display("FAIL rst_mid got busy=%b done=%b bout=%b diff=%h exp all 0",
                        bus.busy, bus.done, bus.bout, bus.diff);
    end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL rst_mid_no_done got=%0d exp=0", pulses); end
  endtask

  task automatic test_back_to_back();
    int         cyc;
    logic       busy1;
    logic [7:0] ra, rb;
    logic       rbin;
    logic [8:0] exp_v;
    for (int i = 0; i < 200; i++) begin
      ra    = 8'($urandom_range(0, 255));
      rb    = 8'($urandom_range(0, 255));
      rbin  = 1'($urandom_range(0, 1));
      exp_v = {1'b0, ra} - {1'b0, rb} - {8'h00, rbin};
      run_op(ra, rb, rbin, cyc, busy1);
      tests++; if (cyc !== 8 || {bus.bout, bus.diff} !== exp_v) begin
        fails++; $display("FAIL rand%0d a=%h b=%h bin=%b cyc=%0d got=%b/%h exp=%b/%h",
                          i, ra, rb, rbin, cyc, bus.bout, bus.diff, exp_v[8], exp_v[7:0]);
      end
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    bus.bin   = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_borrow_edges();
    test_ignore_start();
    test_rst_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
